// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbiter family.
package arb_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Bit width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick: first set bit of req at or after start, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [N-1:0] rot;
  logic [N-1:0] win_rot;

  // start is always below N, so the double-width shift is an exact rotation even for non-power-of-2 N.
  assign rot = N'({req, req} >> start);

  // NOTE: every variable written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    win_rot = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        win_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Rotate the one-hot back into requester numbering.
  assign winner = N'(({win_rot, win_rot} << start) >> N);

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, round-robin or fixed priority, grant lock and optional hold cap.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODE     = MODE_RR,
  parameter int MAX_HOLD = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N-1:0]             req,
  output logic [N-1:0]             grant,
  output logic                     grant_valid,
  output logic [clog2_min1(N)-1:0] grant_idx
);

  localparam int IW = clog2_min1(N);
  localparam int HW = clog2_min1(MAX_HOLD + 1);

  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [HW-1:0] HOLD_CAP = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT = {HW{1'b1}};

  logic [N-1:0]  grant_q,  grant_d;
  logic          valid_q,  valid_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic [IW-1:0] last_q,   last_d;
  logic [HW-1:0] hold_q,   hold_d;

  logic          holder_keeps;
  logic          others_waiting;
  logic          cap_expire;
  logic [N-1:0]  cand;
  logic [IW-1:0] start;
  logic [N-1:0]  winner;
  logic          found;
  logic [IW-1:0] winner_idx;

  assign holder_keeps   = |(grant_q & req);
  assign others_waiting = |(req & ~grant_q);
  assign cap_expire     = (MAX_HOLD > 0) && (hold_q == HOLD_CAP) && others_waiting;

  // On expiry the current holder sits out this pick; someone else is guaranteed to be waiting.
  assign cand = cap_expire ? (req & ~grant_q) : req;

  always_comb begin
    start = '0;
    if (MODE != MODE_FIXED)
      start = (last_q == LAST_RST) ? '0 : last_q + 1'b1;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (cand),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < N; i++)
      if (winner[i]) winner_idx = IW'(i);
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (holder_keeps && !cap_expire) begin
      if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
    end else if (found) begin
      grant_d = winner;
      valid_d = 1'b1;
      idx_d   = winner_idx;
      last_d  = winner_idx;
      hold_d  = HW'(1);
    end else begin
      grant_d = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      hold_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter across round-robin, fixed-priority, capped and N=3 configurations.
module tb_rr_arbiter;

  logic clock;
  logic reset;

  logic [3:0] req_rr,   grant_rr;   logic valid_rr;  logic [1:0] idx_rr;
  logic [3:0] req_fx,   grant_fx;   logic valid_fx;  logic [1:0] idx_fx;
  logic [3:0] req_cap,  grant_cap;  logic valid_cap; logic [1:0] idx_cap;
  logic [2:0] req_n3,   grant_n3;   logic valid_n3;  logic [1:0] idx_n3;

  int checks   = 0;
  int failures = 0;

  // Expected {grant, grant_valid, grant_idx}, zero-extended to seven bits.
  logic [6:0] exp_q [$];

  rr_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_rr (
    .clock(clock), .reset(reset), .req(req_rr),
    .grant(grant_rr), .grant_valid(valid_rr), .grant_idx(idx_rr));

  rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(0)) u_fx (
    .clock(clock), .reset(reset), .req(req_fx),
    .grant(grant_fx), .grant_valid(valid_fx), .grant_idx(idx_fx));

  rr_arbiter #(.N(4), .MODE(0), .MAX_HOLD(3)) u_cap (
    .clock(clock), .reset(reset), .req(req_cap),
    .grant(grant_cap), .grant_valid(valid_cap), .grant_idx(idx_cap));

  rr_arbiter #(.N(3), .MODE(0), .MAX_HOLD(0)) u_n3 (
    .clock(clock), .reset(reset), .req(req_n3),
    .grant(grant_n3), .grant_valid(valid_n3), .grant_idx(idx_n3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp4(input logic [3:0] g);
    logic [1:0] ix;
    ix = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) ix = 2'(i);
    return {g, |g, ix};
  endfunction

  function automatic logic [6:0] exp3(input logic [2:0] g);
    logic [1:0] ix;
    ix = 2'd0;
    for (int i = 0; i < 3; i++) if (g[i]) ix = 2'(i);
    return {1'b0, g, |g, ix};
  endfunction

  task automatic test_reset();
    logic [6:0] e, got;
    reset = 1'b1; req_rr = 4'b1111; req_fx = '0; req_cap = '0; req_n3 = '0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp4(4'b0000));
      @(posedge clock); #1;
      got = {grant_rr, valid_rr, idx_rr};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_hold cycle %0d got=%b expected=%b", i, got, e);
      end
    end
    checks++;
    if ({grant_fx, grant_cap, grant_n3, valid_fx, valid_cap, valid_n3} !== '0) begin
      failures++;
      $display("FAIL reset_others got=%b/%b/%b expected all zero", grant_fx, grant_cap, grant_n3);
    end
    reset = 1'b0;
    exp_q.push_back(exp4(4'b0001));
    @(posedge clock); #1;
    got = {grant_rr, valid_rr, idx_rr};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset_first_grant got=%b expected=%b", got, e);
    end
  endtask

  task automatic test_rr_rotation();
    logic [3:0] reqs [14] = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111,
                              4'b0111, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] exps [14] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                              4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [6:0] e, got;
    for (int i = 0; i < 14; i++) begin
      req_rr = reqs[i];
      exp_q.push_back(exp4(exps[i]));
      @(posedge clock); #1;
      got = {grant_rr, valid_rr, idx_rr};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL rr_rotation step %0d req=%b got=%b expected=%b", i, reqs[i], got, e);
      end
    end
  endtask

  task automatic test_fixed_lock();
    logic [3:0] reqs [11] = '{4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0011,
                              4'b0010, 4'b0110, 4'b1100, 4'b1011, 4'b0000};
    logic [3:0] exps [11] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001,
                              4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0000};
    logic [6:0] e, got;
    for (int i = 0; i < 11; i++) begin
      req_fx = reqs[i];
      exp_q.push_back(exp4(exps[i]));
      @(posedge clock); #1;
      got = {grant_fx, valid_fx, idx_fx};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL fixed_lock step %0d req=%b got=%b expected=%b", i, reqs[i], got, e);
      end
    end
  endtask

  task automatic test_hold_cap();
    logic [3:0] exps [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                              4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic [6:0] e, got;
    req_cap = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(exp4(exps[i]));
      @(posedge clock); #1;
      got = {grant_cap, valid_cap, idx_cap};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL hold_cap_rotate cycle %0d got=%b expected=%b", i, got, e);
      end
    end
    req_cap = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp4(4'b0001));
      @(posedge clock); #1;
      got = {grant_cap, valid_cap, idx_cap};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL hold_cap_alone cycle %0d got=%b expected=%b", i, got, e);
      end
    end
    req_cap = 4'b0000;
    exp_q.push_back(exp4(4'b0000));
    @(posedge clock); #1;
    got = {grant_cap, valid_cap, idx_cap};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL hold_cap_release got=%b expected=%b", got, e);
    end
  endtask

  task automatic test_wrap_n3();
    logic [2:0] reqs [6] = '{3'b101, 3'b000, 3'b101, 3'b101, 3'b001, 3'b000};
    logic [2:0] exps [6] = '{3'b001, 3'b000, 3'b100, 3'b100, 3'b001, 3'b000};
    logic [6:0] e, got;
    for (int i = 0; i < 6; i++) begin
      req_n3 = reqs[i];
      exp_q.push_back(exp3(exps[i]));
      @(posedge clock); #1;
      got = {1'b0, grant_n3, valid_n3, idx_n3};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL wrap_n3 step %0d req=%b got=%b expected=%b", i, reqs[i], got, e);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [6:0] e, got;
    req_rr = 4'b0010;
    exp_q.push_back(exp4(4'b0010));
    @(posedge clock); #1;
    got = {grant_rr, valid_rr, idx_rr};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL mid_reset_setup got=%b expected=%b", got, e);
    end
    reset = 1'b1;
    exp_q.push_back(exp4(4'b0000));
    @(posedge clock); #1;
    got = {grant_rr, valid_rr, idx_rr};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL mid_reset_drop got=%b expected=%b", got, e);
    end
    reset = 1'b0;
    req_rr = 4'b0110;
    exp_q.push_back(exp4(4'b0010));
    @(posedge clock); #1;
    got = {grant_rr, valid_rr, idx_rr};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL mid_reset_pointer got=%b expected=%b", got, e);
    end
    req_rr = 4'b0000;
  endtask

  // Randomised traffic on the capped instance against an index-level reference model.
  task automatic test_random_cap();
    int h = -1;
    int last = 3;
    int hold = 0;
    int w;
    int c;
    bit expire;
    logic [3:0] r, eg;
    logic [6:0] e, got;
    for (int cyc = 0; cyc < 300; cyc++) begin
      r = 4'($urandom_range(0, 15));
      if (h >= 0 && $urandom_range(0, 3) != 0) r[h] = 1'b1;
      expire = (h >= 0) && (hold == 3) && ((r & ~(4'b0001 << h)) != 4'b0000);
      if (h >= 0 && r[h] && !expire) begin
        if (hold < 3) hold++;
      end else begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          c = (last + k) % 4;
          if (w < 0 && r[c] && !(expire && c == h)) w = c;
        end
        if (w >= 0) begin
          h = w; last = w; hold = 1;
        end else begin
          h = -1;
        end
      end
      eg = (h >= 0) ? (4'b0001 << h) : 4'b0000;
      req_cap = r;
      exp_q.push_back(exp4(eg));
      @(posedge clock); #1;
      got = {grant_cap, valid_cap, idx_cap};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL random_cap cycle %0d req=%b got=%b expected=%b", cyc, r, got, e);
      end
    end
    req_cap = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    req_rr = '0; req_fx = '0; req_cap = '0; req_n3 = '0;
    test_reset();
    test_rr_rotation();
    test_fixed_lock();
    test_hold_cap();
    test_wrap_n3();
    test_reset_mid_grant();
    test_random_cap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- N-way arbiter with a registered one-hot grant. It generalises the team's 2-input grant latch to N requesters.
- Selectable round-robin or fixed-priority mode.
- Grant lock while the holder keeps requesting, plus an optional hold-time cap that forces rotation so no requester starves.
- Sits in front of shared resources (bus, memory port) and replaces ad-hoc two-requester arbiters.

Parameters:
- N, 4, number of requesters (2..32).
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAX_HOLD, 0, maximum consecutive grant cycles per holder when another requester is waiting; 0 = unlimited.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset. One clock; reset sampled only on the posedge of clock.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  registered one-hot grant, or all-zero when idle.
- grant_valid  output  1  OR of grant, registered.
- grant_idx  output  $clog2(N) (min 1)  index of the granted requester; 0 when idle.

Behaviour:
- Reset (reset=1 at posedge):
  - grant=0, grant_valid=0, grant_idx=0.
  - Round-robin pointer last=N-1, so requester 0 has first priority after reset.
  - Hold counter=0.
  - Reset overrides req on the same edge; reset mid-grant drops the grant on that edge.
- Latency: req sampled at posedge k drives grant after posedge k. There is no combinational path req->grant.
- Each posedge, when not in reset:
  - Holder h exists, req[h]=1, and no cap expiry: keep grant; hold_cnt++ (saturating).
  - Otherwise: pick a new winner from req, with the candidate set described below. None -> grant=0. Winner w -> grant=1<<w, last=w, hold_cnt=1.
- Cap expiry: MAX_HOLD>0 AND hold_cnt==MAX_HOLD AND (req & ~grant)!=0.
  - On expiry, the holder is excluded from the candidate set for that pick.
  - If no other requester remains, the holder keeps the grant; this cannot occur given the expiry definition.
- Release handover is zero-bubble: the holder drops req at edge k and another requester with req high is granted on the same edge k.
- Winner selection:
  - MODE 0: first set bit scanning last+1, last+2, ..., wrapping modulo N. A lone requester can be re-granted immediately after its own release.
  - MODE 1: lowest set index. last is still updated but has no effect on selection.
- Without a cap, hold_cnt saturates at its max value and never wraps.
- A holder with req still high is never preempted except by cap expiry. Simultaneous new requests have no effect until release or expiry.
- Invariants: grant is at most one-hot; grant_valid==|grant; grant_idx matches grant; grant[i]=1 implies req[i] was 1 at the granting edge.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD+1), min 1.
  - Index arithmetic wraps modulo N; non-power-of-2 N is handled explicitly, not by bit truncation.

Decomposition:
- Shared package arb_pkg: MODE_RR=0, MODE_FIXED=1 constants; function clog2_min1.
- One sub-module, rr_pick: combinational. Inputs are a request vector and a start index (start = last+1 mod N in MODE 0, 0 in MODE 1). Outputs are a one-hot winner and a found flag. Implemented as a double-width rotate-and-priority-encode.
- The top level holds the registers, the hold/cap logic and the candidate masking.

Test Plan:
- Reset and idle (N=4): assert reset 2 cycles with req=4'b1111 -> grant=0, grant_valid=0 throughout reset. First edge after release -> grant=4'b0001, grant_idx=0.
- Round-robin rotation (MODE 0, MAX_HOLD=0): req=4'b1111, each holder drops its bit for one cycle after 2 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001. Each handover happens with no idle cycle.
- Lock and fixed priority (MODE 1): grant held on 0100 with req=4'b0100. Raise req[0] -> grant stays 0100 until req[2] drops, then 0001 on that edge.
- Hold cap (MODE 0, MAX_HOLD=3): req=4'b0011 constant -> grant 0001 for exactly 3 cycles, then 0010 for 3, then 0001, repeating. With req=4'b0001 alone -> grant 0001 held indefinitely.
- Non-power-of-2 wrap (N=3, MODE 0): last=2, req=3'b101 -> grant 001. Then last=0, req=3'b101 -> grant 100. grant_idx values 0 and 2 respectively.
- Reset mid-grant: grant=0010 active, reset pulse for 1 cycle -> grant=0 on that edge. Next edge with req=4'b0110 -> grant 0010, because the pointer was reset to N-1.
